alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencing stage directly upstream of mainALU. It accepts (RegSel, Opr) instruction pairs over a valid/ready stream and buffers them in a small FIFO. It drives one pair at a time onto the combinational mainALU inputs, waits a programmable settle time, then captures Res/Stat into registered outputs. Each captured result carries a sequence tag and is presented downstream on a valid/ready stream; captured Stat bits are also accumulated into a sticky register.

Parameters:
DEPTH, 4, instruction FIFO entries; power of two, 2..16.
SETTLE, 1, extra cycles the ALU inputs are held before capture; 0..15.
TAGW, 4, width of sequence tag.

Ports:
Clk  input  1  rising-edge clock.
Rst  input  1  synchronous, active-high reset.
InValid  input  1  upstream instruction valid.
InReady  output  1  FIFO can accept; equals !full (registered occupancy).
InRegSel  input  4  register select for instruction.
InOpr  input  4  opcode for instruction.
RegSel  output  4  to mainALU RegSel, registered.
Opr  output  4  to mainALU Opr, registered.
Res  input  8  from mainALU result.
Stat  input  8  from mainALU status.
OutValid  output  1  captured result valid.
OutReady  input  1  downstream accepts result.
OutRes  output  8  captured Res.
OutStat  output  8  captured Stat.
OutTag  output  TAGW  sequence number of captured result.
StickyStat  output  8  OR of all OutStat captured since reset/clear.
StatClr  input  1  clears StickyStat.
Busy  output  1  high when state != IDLE or FIFO non-empty.

Behaviour:
- Reset (Rst=1 at edge): FIFO emptied, state IDLE, RegSel=0, Opr=0, OutValid=0, OutRes=0, OutStat=0, OutTag=0, StickyStat=0, settle counter=0. Reset mid-operation discards queued and in-flight instructions; no result is emitted for them.
- FIFO: push on InValid&&InReady. InReady=!full from registered count; a push is refused when full even if a pop occurs the same cycle. Simultaneous push and pop when not full: count unchanged. Order strictly FIFO; read/write pointers wrap modulo DEPTH.
- FSM states IDLE, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop head, register it onto RegSel/Opr, load cnt=SETTLE, go WAIT; else stay.
- WAIT: if cnt==0, capture OutRes<=Res, OutStat<=Stat, OutTag<=tag counter, OutValid<=1, tag counter increments (wraps 2^TAGW-1 -> 0), StickyStat<=StickyStat|Stat, go HOLD; else cnt--.
- HOLD: RegSel/Opr and Out* held stable. On OutValid&&OutReady, OutValid<=0 and go IDLE. Back-to-back issue therefore has one idle cycle between results.
- Latency: instruction accepted at edge k into an empty, idle block -> OutValid high after edge k+2+SETTLE.
- RegSel/Opr change only on IDLE->WAIT; they retain the last issued value otherwise.
- StatClr: StickyStat<=0. If it coincides with a capture, the result is StickyStat<=Stat (clear first, then OR).
- FIFO fills while HOLD is stalled by OutReady=0; no instruction is lost or duplicated.

Test Plan:
Bench stub ALU: Res={RegSel,Opr}, Stat={Opr,RegSel}.
1. Reset, push (0001,0101), OutReady=1, SETTLE=1 -> OutValid high 3 edges after accept; OutRes=0x15, OutStat=0x51, OutTag=0; RegSel=0001, Opr=0101.
2. Push 4 pairs: (0110,0110), (0010,0111), (1101,0100), (1100,1001) back-to-back -> results OutRes=0x66, 0x27, 0xD4, 0xC9 in order, tags 0..3, StickyStat=0x66|0x72|0x4D|0x9C=0xFF.
3. OutReady=0, push 6 pairs with DEPTH=4 -> InReady drops after the FIFO holds 4 with 1 in HOLD; release OutReady -> all accepted pairs emerge in order, none lost.
4. 17 single instructions -> OutTag runs 0..15 then 0.
5. Assert Rst while in WAIT with 2 queued -> all outputs return to reset values next edge; Busy=0; no OutValid follows.
6. StatClr on the capture edge of (1001,0011) -> StickyStat=0x39, not OR'd with prior value; StatClr alone -> StickyStat=0x00.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in and result-out streams between alu_issue_ctrl and its neighbours.
// Latency: none; this is wiring only.
// Backpressure: InReady throttles the producer, OutReady throttles the result stream.
interface alu_issue_ctrl_if #(
  parameter int TAGW = 4
) ();
  // Upstream instruction stream
  logic            InValid;
  logic            InReady;
  logic [3:0]      InRegSel;
  logic [3:0]      InOpr;

  // Downstream result stream
  logic            OutValid;
  logic            OutReady;
  logic [7:0]      OutRes;
  logic [7:0]      OutStat;
  logic [TAGW-1:0] OutTag;

  // Block side: consumes instructions, produces results
  modport slave (
    input  InValid, InRegSel, InOpr, OutReady,
    output InReady, OutValid, OutRes, OutStat, OutTag
  );

  // Environment side: produces instructions, consumes results
  modport master (
    output InValid, InRegSel, InOpr, OutReady,
    input  InReady, OutValid, OutRes, OutStat, OutTag
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Queues (RegSel,Opr) pairs, drives them to mainALU, captures Res/Stat after a settle time.
// Latency: accept at edge k into an idle empty block -> OutValid after edge k+2+SETTLE.
// Backpressure: OutReady=0 holds the result in HOLD; the FIFO fills and InReady drops when full.
module alu_issue_ctrl #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int TAGW   = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  alu_issue_ctrl_if.slave io,
  output logic [3:0] RegSel,
  output logic [3:0] Opr,
  input  logic [7:0] Res,
  input  logic [7:0] Stat,
  output logic [7:0] StickyStat,
  input  logic       StatClr,
  output logic       Busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Instruction FIFO storage: {RegSel, Opr} per entry
  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;

  logic [3:0]      r_regsel;
  logic [3:0]      r_opr;
  logic            r_out_vld;
  logic [7:0]      r_out_res;
  logic [7:0]      r_out_stat;
  logic [TAGW-1:0] r_out_tag;
  logic [TAGW-1:0] r_tag;
  logic [7:0]      r_sticky;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_release;
  logic [7:0]      w_head;

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens room for a push.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = io.InValid && !w_full;
  assign w_head  = r_mem[r_rptr];

  // FIFO storage write; contents need no reset because occupancy gates reads
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {io.InRegSel, io.InOpr};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Issue FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue FSM next-state: IDLE issues, WAIT settles, HOLD waits for the consumer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!w_empty)          w_state_nxt = S_WAIT;
      S_WAIT: if (r_cnt == 4'd0)     w_state_nxt = S_HOLD;
      S_HOLD: if (w_release)         w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // Issue FSM decoded strobes for the datapath
  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: w_pop     = !w_empty;
      S_WAIT: w_capture = (r_cnt == 4'd0);
      S_HOLD: w_release = r_out_vld && io.OutReady;
      default: ;
    endcase
  end

  // ALU operand registers and settle counter; operands only move on issue
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_regsel <= '0;
      r_opr    <= '0;
      r_cnt    <= '0;
    end else if (w_pop) begin
      r_regsel <= w_head[7:4];
      r_opr    <= w_head[3:0];
      r_cnt    <= 4'(SETTLE);
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Result capture, sequence tag and result-valid handshake
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out_vld  <= 1'b0;
      r_out_res  <= '0;
      r_out_stat <= '0;
      r_out_tag  <= '0;
      r_tag      <= '0;
    end else if (w_capture) begin
      r_out_vld  <= 1'b1;
      r_out_res  <= Res;
      r_out_stat <= Stat;
      r_out_tag  <= r_tag;
      r_tag      <= r_tag + 1'b1;
    end else if (w_release) begin
      r_out_vld  <= 1'b0;
    end
  end

  // Sticky status: a clear coinciding with a capture keeps only the new Stat
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sticky <= '0;
    end else if (StatClr) begin
      r_sticky <= w_capture ? Stat : 8'h00;
    end else if (w_capture) begin
      r_sticky <= r_sticky | Stat;
    end
  end

  assign io.InReady  = !w_full;
  assign io.OutValid = r_out_vld;
  assign io.OutRes   = r_out_res;
  assign io.OutStat  = r_out_stat;
  assign io.OutTag   = r_out_tag;
  assign RegSel      = r_regsel;
  assign Opr         = r_opr;
  assign StickyStat  = r_sticky;
  assign Busy        = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a stub ALU (Res={RegSel,Opr}, Stat={Opr,RegSel}).
// Latency: checks issue-to-result timing and result ordering against hand-computed values.
// Backpressure: exercises OutReady stalls filling the FIFO until InReady drops.
module tb_alu_issue_ctrl;

  logic       Clk;
  logic       Rst;
  logic [3:0] RegSel;
  logic [3:0] Opr;
  logic [7:0] Res;
  logic [7:0] Stat;
  logic [7:0] StickyStat;
  logic       StatClr;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_res  [$];
  logic [7:0] q_stat [$];
  logic [3:0] q_tag  [$];

  alu_issue_ctrl_if #(.TAGW(4)) ifc ();

  alu_issue_ctrl #(.DEPTH(4), .SETTLE(1), .TAGW(4)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .io         (ifc),
    .RegSel     (RegSel),
    .Opr        (Opr),
    .Res        (Res),
    .Stat       (Stat),
    .StickyStat (StickyStat),
    .StatClr    (StatClr),
    .Busy       (Busy)
  );

  // Stub mainALU
  always_comb begin
    Res  = {RegSel, Opr};
    Stat = {Opr, RegSel};
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Record every result handshake, sampled mid-cycle
  always @(negedge Clk) begin
    if (!Rst && ifc.OutValid && ifc.OutReady) begin
      q_res.push_back(ifc.OutRes);
      q_stat.push_back(ifc.OutStat);
      q_tag.push_back(ifc.OutTag);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_res.delete();
    q_stat.delete();
    q_tag.delete();
  endtask

  task automatic do_reset();
    Rst          = 1'b1;
    ifc.InValid  = 1'b0;
    ifc.InRegSel = '0;
    ifc.InOpr    = '0;
    StatClr      = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  // Present one pair and return #1 after the edge that accepted it; InValid stays high
  task automatic push(input logic [3:0] rs, input logic [3:0] op);
    logic hs;
    int   n;
    ifc.InValid  = 1'b1;
    ifc.InRegSel = rs;
    ifc.InOpr    = op;
    n = 0;
    do begin
      hs = ifc.InReady;
      @(posedge Clk);
      #1;
      n++;
    end while (!hs && n < 100);
    if (!hs) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_results(input int n, input int budget);
    int c;
    c = 0;
    while (q_res.size() < n && c < budget) begin
      @(posedge Clk);
      c++;
    end
    if (q_res.size() < n) chk("result_timeout", q_res.size(), n);
    @(posedge Clk);
    #1;
  endtask

  logic [7:0] t2_res [4] = '{8'h66, 8'h27, 8'hD4, 8'hC9};
  logic [7:0] t2_stat[4] = '{8'h66, 8'h72, 8'h4D, 8'h9C};
  logic [3:0] t3_rs  [6] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
  logic [3:0] t3_op  [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [7:0] t3_res [6] = '{8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F};

  initial begin
    int lat;
    logic [3:0] iv;
    ifc.OutReady = 1'b1;

    // 1: reset values, then single instruction latency and capture
    do_reset();
    clear_q();
    chk("rst_outvalid", ifc.OutValid, 0);
    chk("rst_outres",   ifc.OutRes, 0);
    chk("rst_outstat",  ifc.OutStat, 0);
    chk("rst_outtag",   ifc.OutTag, 0);
    chk("rst_regsel",   RegSel, 0);
    chk("rst_opr",      Opr, 0);
    chk("rst_sticky",   StickyStat, 0);
    chk("rst_busy",     Busy, 0);
    chk("rst_inready",  ifc.InReady, 1);
    push(4'b0001, 4'b0101);
    ifc.InValid = 1'b0;
    lat = 0;
    while (!ifc.OutValid && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    chk("t1_latency", lat, 3);
    chk("t1_outres",  ifc.OutRes, 8'h15);
    chk("t1_outstat", ifc.OutStat, 8'h51);
    chk("t1_outtag",  ifc.OutTag, 0);
    chk("t1_regsel",  RegSel, 4'b0001);
    chk("t1_opr",     Opr, 4'b0101);
    repeat (3) @(posedge Clk);
    #1;

    // 2: four back-to-back pairs, order, tags and sticky accumulation
    do_reset();
    clear_q();
    push(4'b0110, 4'b0110);
    push(4'b0010, 4'b0111);
    push(4'b1101, 4'b0100);
    push(4'b1100, 4'b1001);
    ifc.InValid = 1'b0;
    wait_results(4, 200);
    for (int i = 0; i < 4 && i < q_res.size(); i++) begin
      chk($sformatf("t2_res%0d", i),  q_res[i],  t2_res[i]);
      chk($sformatf("t2_stat%0d", i), q_stat[i], t2_stat[i]);
      chk($sformatf("t2_tag%0d", i),  q_tag[i],  i);
    end
    chk("t2_sticky", StickyStat, 8'hFF);
    chk("t2_idle_busy", Busy, 0);

    // 3: stall downstream, fill the FIFO, then drain with nothing lost
    clear_q();
    ifc.OutReady = 1'b0;
    for (int i = 0; i < 5; i++) push(t3_rs[i], t3_op[i]);
    ifc.InRegSel = t3_rs[5];
    ifc.InOpr    = t3_op[5];
    repeat (3) @(posedge Clk);
    #1;
    chk("t3_full_inready", ifc.InReady, 0);
    chk("t3_full_busy",    Busy, 1);
    chk("t3_hold_valid",   ifc.OutValid, 1);
    chk("t3_hold_res",     ifc.OutRes, 8'h3A);
    chk("t3_hold_tag",     ifc.OutTag, 4);
    chk("t3_hold_regsel",  RegSel, 4'h3);
    chk("t3_none_yet",     q_res.size(), 0);
    ifc.OutReady = 1'b1;
    push(t3_rs[5], t3_op[5]);
    ifc.InValid = 1'b0;
    wait_results(6, 300);
    chk("t3_count", q_res.size(), 6);
    for (int i = 0; i < 6 && i < q_res.size(); i++) begin
      chk($sformatf("t3_res%0d", i), q_res[i], t3_res[i]);
      chk($sformatf("t3_tag%0d", i), q_tag[i], 4 + i);
    end

    // 4: seventeen results, tag wraps 15 -> 0
    do_reset();
    clear_q();
    for (int i = 0; i < 17; i++) begin
      iv = 4'(i);
      push(iv, ~iv);
    end
    ifc.InValid = 1'b0;
    wait_results(17, 400);
    for (int i = 0; i < 17 && i < q_res.size(); i++) begin
      iv = 4'(i);
      chk($sformatf("t4_tag%0d", i), q_tag[i], i % 16);
      chk($sformatf("t4_res%0d", i), q_res[i], {iv, ~iv});
    end

    // 5: reset while in WAIT with two instructions queued
    do_reset();
    clear_q();
    push(4'h2, 4'h3);
    push(4'h4, 4'h5);
    push(4'h6, 4'h7);
    chk("t5_pre_busy",  Busy, 1);
    chk("t5_pre_valid", ifc.OutValid, 0);
    chk("t5_pre_regsel", RegSel, 4'h2);
    Rst = 1'b1;
    ifc.InValid = 1'b0;
    @(posedge Clk);
    #1;
    chk("t5_valid",  ifc.OutValid, 0);
    chk("t5_regsel", RegSel, 0);
    chk("t5_opr",    Opr, 0);
    chk("t5_res",    ifc.OutRes, 0);
    chk("t5_tag",    ifc.OutTag, 0);
    chk("t5_busy",   Busy, 0);
    chk("t5_inready", ifc.InReady, 1);
    Rst = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    chk("t5_no_result", q_res.size(), 0);
    chk("t5_busy_after", Busy, 0);

    // 6: StatClr coinciding with a capture, then StatClr alone
    clear_q();
    push(4'b0001, 4'b0010);
    ifc.InValid = 1'b0;
    wait_results(1, 50);
    chk("t6_sticky_prior", StickyStat, 8'h21);
    push(4'b1001, 4'b0011);
    ifc.InValid = 1'b0;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    StatClr = 1'b1;
    @(posedge Clk);
    #1;
    StatClr = 1'b0;
    chk("t6_cap_valid",  ifc.OutValid, 1);
    chk("t6_cap_res",    ifc.OutRes, 8'h93);
    chk("t6_clr_cap",    StickyStat, 8'h39);
    repeat (3) @(posedge Clk);
    #1;
    StatClr = 1'b1;
    @(posedge Clk);
    #1;
    StatClr = 1'b0;
    chk("t6_clr_alone", StickyStat, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
